// File: rtl/io_port_sequencer.sv
// io_port_sequencer
//   Drives the user-area mprj_io pads with a programmed sequence of output
//   patterns. A small table holds pattern+hold entries. On start, the block
//   walks entries 0..last_idx and presents each for hold+1 cycles. It can
//   wrap back to entry 0 while loop_en is high. Otherwise it parks on the
//   last pattern. Abort releases the pins.
//
// Ports
//   clock        system clock
//   resetb       asynchronous active-low reset (also clears the table)
//   tbl_we       table write strobe (honoured only outside RUN)
//   tbl_addr     table entry index
//   tbl_pattern  pattern value for the addressed entry
//   tbl_hold     entry duration, presented for hold+1 cycles
//   oeb_mask     per-pin output enable while running (0 = driven), latched at start
//   last_idx     final entry index, latched at start
//   loop_en      level; wrap to entry 0 after last_idx
//   start        pulse; begin the sequence (ignored while running)
//   abort        pulse; return to idle and release pins (wins over start)
//   io_out       pad output values
//   io_oeb       pad output enables, active-low
//   busy         high while the sequence is running
//   done         one-cycle pulse when a non-looping sequence completes
//   step_idx     table entry currently presented
//   wr_err       one-cycle pulse when a table write is dropped during RUN
module io_port_sequencer #(
  parameter int                NIO      = 38,
  parameter int                DEPTH    = 8,
  parameter int                HOLD_W   = 16,
  parameter logic [NIO-1:0]    IDLE_VAL = {NIO{1'b1}},
  localparam int               AW       = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic [NIO-1:0]    tbl_pattern,
  input  logic [HOLD_W-1:0] tbl_hold,
  input  logic [NIO-1:0]    oeb_mask,
  input  logic [AW-1:0]     last_idx,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic [NIO-1:0]    io_out,
  output logic [NIO-1:0]    io_oeb,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     step_idx,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PARKED = 2'd2
  } state_t;

  state_t              state_reg;
  logic [NIO-1:0]      mask_reg;
  logic [AW-1:0]       last_reg;
  logic [HOLD_W-1:0]   cnt_reg;

  // Pattern table. It is built from flops rather than block RAM because
  // reset must clear every entry.
  logic [NIO-1:0]      pat_mem  [DEPTH];
  logic [HOLD_W-1:0]   hold_mem [DEPTH];

  logic                tbl_accept;
  logic [AW-1:0]       step_next;

  assign tbl_accept = tbl_we && (state_reg != ST_RUN);
  assign step_next  = step_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
          pat_mem[gi]  <= '0;
          hold_mem[gi] <= '0;
        end else if (tbl_accept && (tbl_addr == AW'(gi))) begin
          pat_mem[gi]  <= tbl_pattern;
          hold_mem[gi] <= tbl_hold;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg <= ST_IDLE;
      mask_reg  <= {NIO{1'b1}};
      last_reg  <= '0;
      cnt_reg   <= '0;
      io_out    <= IDLE_VAL;
      io_oeb    <= {NIO{1'b1}};
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      wr_err    <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= 1'b0;
      if (abort) begin
        // Abort beats everything, including a same-cycle start or a dropped write.
        state_reg <= ST_IDLE;
        io_out    <= IDLE_VAL;
        io_oeb    <= {NIO{1'b1}};
        busy      <= 1'b0;
        step_idx  <= '0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_PARKED: begin
            if (start) begin
              state_reg <= ST_RUN;
              mask_reg  <= oeb_mask;
              last_reg  <= last_idx;
              step_idx  <= '0;
              io_out    <= pat_mem[0];
              io_oeb    <= oeb_mask;
              cnt_reg   <= hold_mem[0];
              busy      <= 1'b1;
            end
          end
          ST_RUN: begin
            wr_err <= tbl_we;
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else if (step_idx != last_reg) begin
              step_idx <= step_next;
              io_out   <= pat_mem[step_next];
              cnt_reg  <= hold_mem[step_next];
            end else if (loop_en) begin
              step_idx <= '0;
              io_out   <= pat_mem[0];
              cnt_reg  <= hold_mem[0];
            end else begin
              // Park: keep the last pattern driven under the latched mask.
              state_reg <= ST_PARKED;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            io_out    <= IDLE_VAL;
            io_oeb    <= {NIO{1'b1}};
            busy      <= 1'b0;
            step_idx  <= '0;
          end
        endcase
        // Keep the output enables tied to the latched mask outside IDLE.
        if (state_reg == ST_PARKED && !start) io_oeb <= mask_reg;
      end
    end
  end

endmodule

// File: tb/tb_io_port_sequencer.sv
// Testbench for io_port_sequencer. Directed steps with randomised table
// contents. The expected pad waveform is derived from a table model.
module tb_io_port_sequencer;
  localparam int NIO = 38, DEPTH = 8, AW = 3, HOLD_W = 16;
  localparam logic [NIO-1:0] IDLE_V = {NIO{1'b1}};
  localparam logic [NIO-1:0] ALL1   = {NIO{1'b1}};

  logic              clock = 1'b0;
  logic              resetb;
  logic              tbl_we = 1'b0;
  logic [AW-1:0]     tbl_addr = '0;
  logic [NIO-1:0]    tbl_pattern = '0;
  logic [HOLD_W-1:0] tbl_hold = '0;
  logic [NIO-1:0]    oeb_mask = '0;
  logic [AW-1:0]     last_idx = '0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NIO-1:0]    io_out;
  logic [NIO-1:0]    io_oeb;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;
  logic              wr_err;

  io_port_sequencer #(.NIO(NIO), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clock(clock), .resetb(resetb), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_pattern(tbl_pattern), .tbl_hold(tbl_hold), .oeb_mask(oeb_mask),
    .last_idx(last_idx), .loop_en(loop_en), .start(start), .abort(abort),
    .io_out(io_out), .io_oeb(io_oeb), .busy(busy), .done(done),
    .step_idx(step_idx), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference table contents
  logic [NIO-1:0]    m_pat  [DEPTH];
  int                m_hold [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".io_out"}, 64'(io_out), 64'(IDLE_V));
    chk({tag, ".io_oeb"}, 64'(io_oeb), 64'(ALL1));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".step"}, 64'(step_idx), 64'd0);
  endtask

  task automatic write_entry(input int a, input logic [NIO-1:0] p, input int h);
    tbl_we = 1'b1; tbl_addr = AW'(a); tbl_pattern = p; tbl_hold = HOLD_W'(h);
    tick();
    tbl_we = 1'b0;
    m_pat[a] = p; m_hold[a] = h;
    chk("wr.wr_err", 64'(wr_err), 64'd0);
  endtask

  // Runs a sequence from IDLE/PARKED and checks it cycle by cycle.
  // With abort_end the sequence keeps looping and is aborted after `loops`
  // passes. Otherwise loop_en drops during the final pass and the block parks.
  task automatic run_seq(input int last, input logic [NIO-1:0] mask,
                         input int loops, input bit abort_end);
    logic [NIO-1:0] q_pat [$];
    int             q_idx [$];
    oeb_mask = mask; last_idx = AW'(last);
    loop_en = (loops > 1) || abort_end;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Changing these after start must not disturb the running sequence.
    oeb_mask = {$urandom, $urandom};
    last_idx = AW'($urandom);
    for (int it = 0; it < loops; it++)
      for (int k = 0; k <= last; k++)
        for (int h = 0; h <= m_hold[k]; h++) begin
          q_pat.push_back(m_pat[k]);
          q_idx.push_back(k);
        end
    for (int c = 0; c < q_pat.size(); c++) begin
      if (!abort_end && c == q_pat.size() - (q_pat.size() / loops)) loop_en = 1'b0;
      chk("run.io_out", 64'(io_out), 64'(q_pat[c]));
      chk("run.io_oeb", 64'(io_oeb), 64'(mask));
      chk("run.busy", 64'(busy), 64'd1);
      chk("run.done", 64'(done), 64'd0);
      chk("run.step", 64'(step_idx), 64'(q_idx[c]));
      tick();
    end
    if (abort_end) begin
      chk("wrap.step", 64'(step_idx), 64'd0);
      chk("wrap.io_out", 64'(io_out), 64'(m_pat[0]));
      chk("wrap.done", 64'(done), 64'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("abort");
    end else begin
      chk("park.done", 64'(done), 64'd1);
      chk("park.busy", 64'(busy), 64'd0);
      chk("park.io_out", 64'(io_out), 64'(m_pat[last]));
      chk("park.io_oeb", 64'(io_oeb), 64'(mask));
      chk("park.step", 64'(step_idx), 64'(last));
      tick();
      chk("park2.done", 64'(done), 64'd0);
      chk("park2.io_out", 64'(io_out), 64'(m_pat[last]));
      chk("park2.io_oeb", 64'(io_oeb), 64'(mask));
    end
    loop_en = 1'b0;
  endtask

  initial begin
    logic [NIO-1:0] p0, p1;
    for (int i = 0; i < DEPTH; i++) begin m_pat[i] = '0; m_hold[i] = 0; end

    // Reset state
    resetb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset");
    chk("reset.wr_err", 64'(wr_err), 64'd0);
    resetb = 1'b1;
    tick();
    chk_idle("post_reset");

    // 1: two entries, single pass, parks on 0x2
    write_entry(0, 38'h1, 2);
    write_entry(1, 38'h2, 0);
    run_seq(1, '0, 1, 0);

    // 2: same table, looping, then abort; then loop_en dropped mid-run
    run_seq(1, '0, 3, 1);
    run_seq(1, '0, 2, 0);

    // Random tables, lengths, masks and pass counts
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, {$urandom, $urandom}, $urandom_range(0, 3));
      run_seq($urandom_range(0, DEPTH - 1), {$urandom, $urandom}, $urandom_range(1, 3), 0);
    end

    // 3: single-entry sequence driving only pin 0 low
    write_entry(0, '0, $urandom_range(0, 2));
    run_seq(0, ~38'h1, 1, 0);

    // 4: table write during RUN is dropped with a wr_err pulse
    write_entry(0, {$urandom, $urandom}, 10);
    write_entry(1, {$urandom, $urandom}, 1);
    oeb_mask = '0; last_idx = 3'd1; loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tbl_we = 1'b1; tbl_addr = 3'd1; tbl_pattern = ~m_pat[1]; tbl_hold = 16'd5;
    tick();
    tbl_we = 1'b0;
    chk("drop.wr_err", 64'(wr_err), 64'd1);
    chk("drop.busy", 64'(busy), 64'd1);
    tick();
    chk("drop.wr_err_clr", 64'(wr_err), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("drop_abort");
    run_seq(1, '0, 1, 0);

    // 5: start and abort together never enter RUN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("to_idle");
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("start_abort");
      tick();
    end

    // Maximum hold: entry 0 lasts 65536 cycles without the counter wrapping
    p0 = {$urandom, $urandom}; p1 = ~p0;
    write_entry(0, p0, 16'hFFFF);
    write_entry(1, p1, 0);
    oeb_mask = '0; last_idx = 3'd1; loop_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (65535) tick();
    chk("maxhold.step", 64'(step_idx), 64'd0);
    chk("maxhold.io_out", 64'(io_out), 64'(p0));
    chk("maxhold.busy", 64'(busy), 64'd1);
    tick();
    chk("maxhold.step1", 64'(step_idx), 64'd1);
    chk("maxhold.io_out1", 64'(io_out), 64'(p1));
    tick();
    chk("maxhold.done", 64'(done), 64'd1);

    // 6: async reset mid-run releases pins without a clock edge, clears table
    oeb_mask = '0; last_idx = 3'd7; loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_reset.busy", 64'(busy), 64'd1);
    resetb = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset.wr_err", 64'(wr_err), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin m_pat[i] = '0; m_hold[i] = 0; end
    tick();
    resetb = 1'b1;
    tick();
    run_seq(7, {$urandom, $urandom}, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
